// File: rtl/pocket_pkg.sv
// pocket: shared video source selection types.
package pocket;
  typedef enum logic {SRC_A, SRC_B} video_sel_t;
  localparam int RGB_W = 24;
endpackage

// File: rtl/video_if.sv
// video_if: one video stream (pixel data plus timing qualifiers).
interface video_if;
  logic [pocket::RGB_W-1:0] rgb;
  logic de;
  logic skip;
  logic vs;
  logic hs;
  modport source (output rgb, de, skip, vs, hs);
  modport sink (input rgb, de, skip, vs, hs);
endinterface

// File: rtl/video_vs_edge.sv
// video_vs_edge: flags the cycle in which vs rises (frame boundary).
module video_vs_edge (
  input  logic rgb_clock,
  input  logic reset,
  input  logic vs,
  output logic boundary
);
  logic vs_q;
  always_ff @(posedge rgb_clock)
    if (reset) vs_q <= 1'b0;
    else vs_q <= vs;
  assign boundary = vs & ~vs_q;
endmodule

// File: rtl/video_source_switch.sv
// video_source_switch: glitch-free switch between two video sources on frame boundaries.
module video_source_switch
  import pocket::*;
#(
  parameter int MUTE_FRAMES = 1,
  parameter int VS_TIMEOUT = 2**20,
  parameter video_sel_t RESET_SEL = SRC_A
) (
  input  logic       rgb_clock,
  input  logic       reset,
  video_if.sink      src_a,
  video_if.sink      src_b,
  video_if.source    video_out,
  input  logic       sel_valid,
  input  video_sel_t sel_target,
  output logic       sel_ready,
  output video_sel_t active_sel,
  output logic       sel_done,
  output logic       timeout_err
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, MUTE = 2'd2;
  logic [1:0] state;
  video_sel_t target_q;
  logic [23:0] tcnt;
  logic [3:0] mcnt;
  logic bnd_a, bnd_b, cur_bnd, sel_b, tmo;
  video_vs_edge u_edge_a (.rgb_clock(rgb_clock), .reset(reset), .vs(src_a.vs), .boundary(bnd_a));
  video_vs_edge u_edge_b (.rgb_clock(rgb_clock), .reset(reset), .vs(src_b.vs), .boundary(bnd_b));
  // active_sel names the old source in DRAIN and the new one in MUTE
  assign sel_b = active_sel == SRC_B;
  assign cur_bnd = sel_b ? bnd_b : bnd_a;
  assign tmo = tcnt == 24'(VS_TIMEOUT - 1);
  assign sel_ready = state == RUN;
  always_ff @(posedge rgb_clock)
    if (reset) begin
      state <= RUN;
      active_sel <= RESET_SEL;
      target_q <= RESET_SEL;
      tcnt <= '0;
      mcnt <= '0;
      sel_done <= 1'b0;
      timeout_err <= 1'b0;
      video_out.rgb <= '0;
      video_out.de <= 1'b0;
      video_out.skip <= 1'b0;
      video_out.vs <= 1'b0;
      video_out.hs <= 1'b0;
    end else begin
      sel_done <= 1'b0;
      timeout_err <= 1'b0;
      video_out.rgb <= state == MUTE ? '0 : (sel_b ? src_b.rgb : src_a.rgb);
      video_out.de <= sel_b ? src_b.de : src_a.de;
      video_out.skip <= sel_b ? src_b.skip : src_a.skip;
      video_out.vs <= sel_b ? src_b.vs : src_a.vs;
      video_out.hs <= sel_b ? src_b.hs : src_a.hs;
      if (state == RUN) begin
        if (sel_valid && sel_target == active_sel) sel_done <= 1'b1;
        else if (sel_valid) begin
          target_q <= sel_target;
          tcnt <= '0;
          state <= DRAIN;
        end
      end else if (state == DRAIN) begin
        tcnt <= tcnt + 24'd1;
        if (cur_bnd || tmo) begin
          active_sel <= target_q;
          mcnt <= 4'(MUTE_FRAMES);
          timeout_err <= ~cur_bnd;
          state <= MUTE;
        end
      end else if (cur_bnd) begin
        mcnt <= mcnt - 4'd1;
        if (mcnt == 4'd1) begin
          sel_done <= 1'b1;
          state <= RUN;
        end
      end
    end
endmodule

// File: tb/tb_video_source_switch.sv
// tb_video_source_switch: directed vectors for the video source switch.
module tb_video_source_switch;
  import pocket::*;
  logic rgb_clock = 1'b0;
  logic reset;
  logic sel_valid;
  video_sel_t sel_target;
  logic sel_ready;
  video_sel_t active_sel;
  logic sel_done;
  logic timeout_err;
  int vectors = 0;
  int miscompares = 0;
  video_if va ();
  video_if vb ();
  video_if vo ();
  video_source_switch #(.MUTE_FRAMES(2), .VS_TIMEOUT(64), .RESET_SEL(SRC_A)) dut (
    .rgb_clock(rgb_clock), .reset(reset), .src_a(va), .src_b(vb), .video_out(vo),
    .sel_valid(sel_valid), .sel_target(sel_target), .sel_ready(sel_ready),
    .active_sel(active_sel), .sel_done(sel_done), .timeout_err(timeout_err)
  );
  always #5 rgb_clock = ~rgb_clock;
  task automatic tick();
    @(posedge rgb_clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    sel_valid = 1'b0;
    sel_target = SRC_A;
    va.rgb = 24'h112233; va.de = 1'b1; va.hs = 1'b1; va.skip = 1'b1; va.vs = 1'b0;
    vb.rgb = 24'hBBBBBB; vb.de = 1'b0; vb.hs = 1'b0; vb.skip = 1'b0; vb.vs = 1'b0;
    tick(); tick();
    check("rst_active", active_sel, SRC_A);
    check("rst_rgb", vo.rgb, 0);
    check("rst_ctl", {vo.de, vo.hs, vo.vs, vo.skip}, 0);
    check("rst_ready", sel_ready, 1);
    check("rst_flags", {sel_done, timeout_err}, 0);
    reset = 1'b0;
    tick();
    check("pass_rgb", vo.rgb, 24'h112233);
    check("pass_ctl", {vo.de, vo.hs, vo.vs, vo.skip}, 4'b1101);
    va.rgb = 24'h445566; va.skip = 1'b0;
    tick();
    check("pass_rgb2", vo.rgb, 24'h445566);
    check("pass_skip", vo.skip, 0);
    sel_valid = 1'b1; sel_target = SRC_A;
    tick();
    sel_valid = 1'b0;
    check("same_done", sel_done, 1);
    check("same_ready", sel_ready, 1);
    check("same_rgb", vo.rgb, 24'h445566);
    tick();
    check("same_done_end", sel_done, 0);
    va.rgb = 24'hAAAAAA; vb.de = 1'b1; vb.hs = 1'b1; vb.skip = 1'b1;
    sel_valid = 1'b1; sel_target = SRC_B;
    tick();
    sel_valid = 1'b0;
    check("drain_ready", sel_ready, 0);
    check("drain_rgb", vo.rgb, 24'hAAAAAA);
    check("drain_active", active_sel, SRC_A);
    sel_valid = 1'b1; sel_target = SRC_A;
    tick();
    sel_valid = 1'b0;
    tick();
    check("drain_ign_done", sel_done, 0);
    check("drain_ign_active", active_sel, SRC_A);
    check("drain_ign_rgb", vo.rgb, 24'hAAAAAA);
    va.vs = 1'b1;
    tick();
    va.vs = 1'b0;
    check("bnd_active", active_sel, SRC_B);
    check("bnd_rgb", vo.rgb, 24'hAAAAAA);
    check("bnd_terr", timeout_err, 0);
    tick();
    check("mute_rgb", vo.rgb, 0);
    check("mute_ctl", {vo.de, vo.hs, vo.vs, vo.skip}, 4'b1101);
    check("mute_ready", sel_ready, 0);
    sel_valid = 1'b1; sel_target = SRC_A;
    tick();
    sel_valid = 1'b0;
    check("mute_ign", active_sel, SRC_B);
    vb.vs = 1'b1;
    tick();
    vb.vs = 1'b0;
    check("mute_vs", vo.vs, 1);
    check("mute_rgb1", vo.rgb, 0);
    tick(); tick();
    check("mute_mid_ready", sel_ready, 0);
    check("mute_mid_done", sel_done, 0);
    vb.vs = 1'b1;
    tick();
    vb.vs = 1'b0;
    check("mute_end_rgb", vo.rgb, 0);
    check("mute_done", sel_done, 1);
    check("mute_end_ready", sel_ready, 1);
    tick();
    check("b_rgb", vo.rgb, 24'hBBBBBB);
    check("b_done_end", sel_done, 0);
    sel_valid = 1'b1; sel_target = SRC_A;
    tick();
    sel_valid = 1'b0;
    repeat (63) tick();
    check("to_pre_active", active_sel, SRC_B);
    check("to_pre_err", timeout_err, 0);
    tick();
    check("to_active", active_sel, SRC_A);
    check("to_err", timeout_err, 1);
    check("to_rgb", vo.rgb, 24'hBBBBBB);
    tick();
    check("to_err_end", timeout_err, 0);
    check("to_mute_rgb", vo.rgb, 0);
    va.vs = 1'b1; tick(); va.vs = 1'b0; tick();
    va.vs = 1'b1; tick(); va.vs = 1'b0;
    check("to_done", sel_done, 1);
    tick();
    check("to_a_rgb", vo.rgb, 24'hAAAAAA);
    sel_valid = 1'b1; sel_target = SRC_B;
    tick();
    sel_valid = 1'b0;
    repeat (63) tick();
    va.vs = 1'b1;
    tick();
    va.vs = 1'b0;
    check("co_active", active_sel, SRC_B);
    check("co_err", timeout_err, 0);
    tick();
    check("co_mute_rgb", vo.rgb, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mute_active", active_sel, SRC_A);
    check("rst_mute_ready", sel_ready, 1);
    check("rst_mute_rgb", vo.rgb, 0);
    check("rst_mute_done", sel_done, 0);
    tick();
    check("rst_mute_done2", sel_done, 0);
    check("rst_mute_pass", vo.rgb, 24'hAAAAAA);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
